// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: default data width, divider FSM
// state encoding and the iteration-counter width.
package hilo_unit_pkg;

  localparam int unsigned HiloLength = 32;
  localparam int unsigned HiloCntW   = $clog2(HiloLength);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StFix  = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/hilo_unit_div_iter.sv
// One restoring-division step, purely combinational.
//   rem      : current partial remainder (always < divisor)
//   quo      : quotient register; its MSB is the next dividend bit shifted in
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the step
//   quo_next : quotient register after the step (new quotient bit in LSB)
module hilo_unit_div_iter #(
  parameter int unsigned LENGTH = 32
) (
  input  logic [LENGTH-1:0] rem,
  input  logic [LENGTH-1:0] quo,
  input  logic [LENGTH-1:0] divisor,
  output logic [LENGTH-1:0] rem_next,
  output logic [LENGTH-1:0] quo_next
);

  // The shifted remainder needs one extra bit: 2*rem+1 can exceed LENGTH bits.
  logic [LENGTH:0]   shifted;
  logic              fits;
  logic [LENGTH-1:0] diff;

  always_comb begin
    shifted = {rem, quo[LENGTH-1]};
    fits    = shifted >= {1'b0, divisor};
    // When it fits the true difference is < divisor, so the low bits are exact.
    diff    = shifted[LENGTH-1:0] - divisor;
    rem_next = fits ? diff : shifted[LENGTH-1:0];
    quo_next = {quo[LENGTH-2:0], fits};
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with an iterative radix-2 restoring divider (DIV/DIVU).
//   clk, rst          : clock, synchronous active-high reset
//   we, wdata_hi/lo   : direct write of both HI and LO (wins over a divider write)
//   div_start         : start a division (accepted only when idle)
//   div_signed        : 1 = signed DIV, 0 = DIVU
//   dividend, divisor : operands, captured with div_start
//   div_cancel        : abort an in-flight division / suppress a same-edge start
//   hi, lo            : registered HI/LO
//   busy              : division in flight (pipeline stall)
//   div_done          : one-cycle pulse after HI/LO take a division result
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned LENGTH = HiloLength
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [LENGTH-1:0] wdata_hi,
  input  logic [LENGTH-1:0] wdata_lo,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [LENGTH-1:0] dividend,
  input  logic [LENGTH-1:0] divisor,
  input  logic              div_cancel,
  output logic [LENGTH-1:0] hi,
  output logic [LENGTH-1:0] lo,
  output logic              busy,
  output logic              div_done
);

  localparam int unsigned CntW = $clog2(LENGTH);

  hilo_state_e       state_q;
  logic [CntW-1:0]   count_q;
  logic [LENGTH-1:0] rem_q, quo_q, dvsr_q;
  logic [LENGTH-1:0] hi_q, lo_q;
  logic              neg_quo_q, neg_rem_q;
  logic              done_q;

  logic [LENGTH-1:0] rem_step, quo_step;
  logic [LENGTH-1:0] quo_fix, rem_fix;
  logic              dd_neg, dv_neg;
  logic [LENGTH-1:0] dd_mag, dv_mag;

  hilo_unit_div_iter #(
    .LENGTH (LENGTH)
  ) u_div_iter (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_comb begin
    dd_neg  = div_signed & dividend[LENGTH-1];
    dv_neg  = div_signed & divisor[LENGTH-1];
    dd_mag  = dd_neg ? -dividend : dividend;
    dv_mag  = dv_neg ? -divisor : divisor;
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (div_start && !div_cancel) begin
            count_q <= '0;
            if (divisor == '0) begin
              // Divide by zero: result is preloaded and the sign fix-up is
              // disabled so FIX writes LO=all-ones, HI=raw dividend.
              rem_q     <= dividend;
              quo_q     <= '1;
              dvsr_q    <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= StFix;
            end else begin
              rem_q     <= '0;
              quo_q     <= dd_mag;
              dvsr_q    <= dv_mag;
              neg_quo_q <= dd_neg ^ dv_neg;
              neg_rem_q <= dd_neg;
              state_q   <= StDiv;
            end
          end
        end
        StDiv: begin
          if (div_cancel) begin
            state_q <= StIdle;
          end else begin
            rem_q   <= rem_step;
            quo_q   <= quo_step;
            count_q <= count_q + CntW'(1);
            if (count_q == CntW'(LENGTH - 1)) begin
              state_q <= StFix;
            end
          end
        end
        StFix: begin
          state_q <= StIdle;
          if (!div_cancel) begin
            hi_q   <= rem_fix;
            lo_q   <= quo_fix;
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Direct write overrides a same-edge divider result.
      if (we) begin
        hi_q <= wdata_hi;
        lo_q <= wdata_lo;
      end
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != StIdle);
  assign div_done = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] wdata_hi = '0, wdata_lo = '0;
  logic        div_start = 1'b0, div_signed = 1'b0, div_cancel = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic [31:0] hi, lo;
  logic        busy, div_done;

  hilo_unit #(
    .LENGTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .wdata_hi   (wdata_hi),
    .wdata_lo   (wdata_lo),
    .div_start  (div_start),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_cancel (div_cancel),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .div_done   (div_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_push = 0;
  logic [63:0] sb_q[$];  // expected {hi, lo} per div_done

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every div_done pops one expected result.
  always @(negedge clk) begin
    if (!rst && div_done) begin
      logic [63:0] e;
      n_done++;
      if (sb_q.size() == 0) begin
        chk("unexpected_div_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_hi", hi, e[63:32]);
        chk("sb_lo", lo, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic push, input logic [31:0] ehi, input logic [31:0] elo);
    if (push) begin
      sb_q.push_back({ehi, elo});
      n_push++;
    end
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    chk("busy_low_at_start", {31'd0, busy}, 32'd0);
    tick();
    div_start  = 1'b0;
  endtask

  // Counts remaining busy cycles, then checks the single-cycle done pulse.
  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk(name, n, exp_cycles);
    chk("done_high", {31'd0, div_done}, 32'd1);
    tick();
    chk("done_one_cycle", {31'd0, div_done}, 32'd0);
  endtask

  initial begin
    int d0;
    tick();
    tick();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, div_done}, 32'd0);
    rst = 1'b0;
    tick();

    // Direct write: no bypass, visible after the edge.
    we = 1'b1; wdata_hi = 32'h1234_5678; wdata_lo = 32'h9ABC_DEF0;
    chk("we_no_bypass", hi, 32'd0);
    tick();
    we = 1'b0;
    chk("we_hi", hi, 32'h1234_5678);
    chk("we_lo", lo, 32'h9ABC_DEF0);
    chk("we_busy", {31'd0, busy}, 32'd0);

    // Directed divisions: {signed, dividend, divisor, hi, lo, busy cycles}.
    start_div(1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    wait_idle("busy_divu", 33);
    start_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    wait_idle("busy_neg_dd", 33);
    start_div(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1, 32'd2, 32'hFFFF_FFF2);
    wait_idle("busy_neg_dv", 33);
    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000);
    wait_idle("busy_ovf", 33);
    start_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'h7FFF_FFFE, 32'd1);
    wait_idle("busy_wide_rem", 33);
    start_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 32'hFFFF_FFFF);
    wait_idle("busy_div1", 33);
    start_div(1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    wait_idle("busy_zero_u", 1);
    start_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    wait_idle("busy_zero_s", 1);

    // Cancel before iteration 10's edge: no write, no done.
    d0 = n_done;
    start_div(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (9) tick();
    div_cancel = 1'b1;
    tick();
    div_cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    repeat (40) tick();
    chk("cancel_hi", hi, 32'hFFFF_FFFB);
    chk("cancel_lo", lo, 32'hFFFF_FFFF);
    chk("cancel_no_done", n_done, d0);

    // Cancel beats a same-edge start in idle.
    div_start = 1'b1; div_cancel = 1'b1; divisor = 32'd3;
    tick();
    div_start = 1'b0; div_cancel = 1'b0;
    chk("cancel_vs_start", {31'd0, busy}, 32'd0);

    // Reset mid-division.
    start_div(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, div_done}, 32'd0);
    repeat (40) tick();
    chk("rstmid_no_done", n_done, d0);

    // we on the FIX edge wins, done still pulses.
    start_div(1'b0, 32'd100, 32'd7, 1'b1, 32'h0000_AAAA, 32'h0000_5555);
    repeat (32) tick();
    we = 1'b1; wdata_hi = 32'h0000_AAAA; wdata_lo = 32'h0000_5555;
    tick();
    we = 1'b0;
    chk("collide_busy", {31'd0, busy}, 32'd0);
    chk("collide_done", {31'd0, div_done}, 32'd1);
    tick();

    // Start while busy is ignored.
    start_div(1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    repeat (5) tick();
    div_start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    tick();
    div_start = 1'b0;
    wait_idle("busy_ignored_start", 27);
    repeat (40) tick();

    chk("sb_drained", sb_q.size(), 32'd0);
    chk("done_count", n_done, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Holds the architectural HI/LO register pair and runs an iterative radix-2 divider that fills it. It sits beside the EX-stage ALU. It feeds the ALU's `LO`/`HI` read inputs and consumes the ALU's `Write_HI`/`Write_LO`/`W_HILO` write-back. It also replaces single-cycle DIVU with a multi-cycle DIV/DIVU that stalls the pipeline through `busy`.

## Interface
Parameters:
- `LENGTH`, default 32: data width of HI, LO and the divider operands.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  direct HI/LO write, driven by ALU `W_HILO` (MULT/MULTU/MTHI/MTLO).
- `wdata_hi`  in  LENGTH  value written to HI when `we`.
- `wdata_lo`  in  LENGTH  value written to LO when `we`.
- `div_start`  in  1  start a division; sampled only in IDLE.
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- `dividend`  in  LENGTH  captured with start.
- `divisor`  in  LENGTH  captured with start.
- `div_cancel`  in  1  pipeline flush; aborts an in-flight division.
- `hi`  out  LENGTH  current HI register.
- `lo`  out  LENGTH  current LO register.
- `busy`  out  1  high while a division is in flight; the stall request.
- `div_done`  out  1  one-cycle pulse on the cycle after HI/LO take a quotient/remainder.

## Operation
- FSM states: IDLE, DIV, FIX.
- **IDLE**
  - On `div_start`, latch the operand magnitudes, `div_signed`, and the operand signs.
  - Clear the partial remainder; load the quotient register with |dividend|.
  - Set iteration count to 0; go to DIV.
- **Zero divisor**
  - `div_start` with `divisor`==0 goes straight to FIX with no iterations.
  - Result: LO=all-ones, HI=dividend (raw, unmodified).
- **DIV**
  - Each edge does one restoring step:
    - Shift {rem, quo} left by 1.
    - Trial-subtract |divisor| from rem.
    - If the result is non-negative, keep it and set the quotient LSB.
  - After LENGTH steps (count==LENGTH-1 on the edge), go to FIX.
- **FIX**
  - Quotient is negated iff `div_signed` and the operand signs differ.
  - Remainder takes the dividend's sign iff `div_signed`.
  - Write LO=quotient, HI=remainder; go to IDLE; pulse `div_done` next cycle.
- **Signed overflow**: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of unsigned magnitude arithmetic; no special case.
- **`we`**
  - Writes both HI and LO at the edge, in any state.
  - If `we` and the FIX write land on the same edge, `we` wins; FIX still returns to IDLE and still pulses `div_done`.
- **`div_start` while busy**: ignored.
- **`div_start` and `we` in IDLE on the same edge**: both accepted; the `we` write lands now, the division result lands later.
- **`div_cancel`**
  - In DIV or FIX: return to IDLE, no HI/LO write, no `div_done`.
  - In IDLE: cancel has priority over a same-edge `div_start`.
- **`rst`**
  - Overrides everything, including mid-division.
  - hi=0, lo=0, busy=0, div_done=0, state=IDLE, count=0, internal datapath cleared.

## Timing
- `hi`/`lo` are register outputs with no combinational bypass; a `we` at edge N is visible after edge N.
- `busy` is combinational from state: `busy`=(state!=IDLE).
  - It is low in the cycle `div_start` is presented.
  - It goes high after the accepting edge E0.
- Normal division:
  - Iterations at edges E1..E32 (LENGTH=32).
  - FIX write at E33.
  - `busy` high for exactly 33 cycles.
  - `div_done` high only in the cycle after E33, with new `hi`/`lo` already visible.
- Zero-divisor division: FIX at E1, `busy` high 1 cycle, `div_done` after E1.
- A new `div_start` is accepted in the same cycle `div_done` is high (state is IDLE).

## Structure
- Shared header `head.v` holds:
  - `LENGTH`
  - FSM state encodings (`HILO_IDLE`, `HILO_DIV`, `HILO_FIX`)
  - iteration-counter width
- One sub-module, `div_iter`: purely combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- `hilo_unit` owns the FSM, counter, operand latches, sign fix-up and HI/LO registers.

## Test plan
- **Reset, then direct write**: reset → hi=lo=0, busy=0. Then `we`, wdata_hi=0x12345678, wdata_lo=0x9ABCDEF0 → visible next cycle, busy stays 0.
- **DIVU**: 100 / 7 → after 33 busy cycles, lo=14, hi=2, one-cycle `div_done`.
- **DIV with signs**:
  - −100 / 7 → lo=0xFFFFFFF2, hi=0xFFFFFFFE.
  - 100 / −7 → lo=0xFFFFFFF2, hi=2.
  - 0x80000000 / −1 → lo=0x80000000, hi=0.
- **Zero divisor**: DIVU 0xDEADBEEF / 0 → busy for 1 cycle, lo=0xFFFFFFFF, hi=0xDEADBEEF.
- **Cancel and reset mid-operation**:
  - `div_cancel` at iteration 10 → busy drops next cycle, hi/lo unchanged, no `div_done`.
  - Repeat using `rst` instead → all outputs 0.
- **Collisions**:
  - `we` (hi=0xAAAA, lo=0x5555) on the FIX edge → hi=0xAAAA, lo=0x5555, `div_done` still pulses.
  - `div_start` during busy → ignored, the first result is unaffected.
